// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART blocks.
// Holds the parity mode encodings, the transmitter FSM state encoding,
// the smallest legal bit divisor and a helper that decodes the parity mode.
// Contents are shared by uart_tx_cfg, uart_bit_timer and the future uart_rx_cfg.
package uart_pkg;

   localparam logic [1:0] UART_PAR_NONE = 2'b00;
   localparam logic [1:0] UART_PAR_EVEN = 2'b01;
   localparam logic [1:0] UART_PAR_ODD  = 2'b10;

   localparam int UART_DIV_MIN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uartState_t;

   // Mode 11 is reserved and behaves like "no parity", so only the two
   // explicit codes switch the parity bit on.
   function automatic logic parityEnabled(input logic [1:0] mode);
      return (mode == UART_PAR_EVEN) || (mode == UART_PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the configurable UART.
// Produces a one-cycle terminal tick every eff_div clocks, where eff_div is
// the divisor clamped to a minimum of UART_DIV_MIN. A restart pulse zeroes
// the count so the next tick comes a full period later.
// Ports:
//   i_Clock   - system clock, rising edge
//   i_Rst_n   - synchronous reset, active low
//   i_Div     - clocks per bit (values below the minimum are clamped)
//   i_Restart - begin a fresh bit period on the next cycle
//   o_Tick    - high on the last cycle of each bit period
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic [DIV_W-1:0] i_Div,
   input  logic             i_Restart,
   output logic             o_Tick
);

   logic [DIV_W-1:0] effDiv;
   logic [DIV_W-1:0] count;

   // Clamp the divisor so a period is never shorter than the minimum, and
   // flag the terminal cycle. Using >= keeps the counter from running all the
   // way around if the divisor ever shrinks below the current count.
   always_comb begin
      effDiv = i_Div;
      if (i_Div < DIV_W'(UART_DIV_MIN)) begin
         effDiv = DIV_W'(UART_DIV_MIN);
      end
      o_Tick = (count >= (effDiv - DIV_W'(1)));
   end

   // Free-running period counter; restart and the terminal tick both wrap it
   // back to zero so each period is exactly effDiv cycles long.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         count <= '0;
      end else if (i_Restart || o_Tick) begin
         count <= '0;
      end else begin
         count <= count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a one-deep holding register.
// Sends start, DATA_BITS data bits LSB first, optional even/odd parity and one
// or two stop bits. Frames chain back-to-back without an idle gap when the
// holding register is refilled in time. Drives an RS-485 driver enable that
// stays high across chained frames.
// Ports:
//   i_Clock, i_Rst_n            - clock and synchronous active-low reset
//   i_Div, i_Div_Load           - clocks per bit and its load strobe
//   i_Parity_Mode, i_Two_Stop   - frame format, latched at frame start
//   i_Tx_DV, i_Tx_Data          - write side of the valid/ready handshake
//   o_Tx_Ready                  - holding register empty
//   o_Tx_Serial                 - serial line, idle high
//   o_Tx_Enable, o_Tx_Active    - high for the whole span of transmitted bits
//   o_Tx_Done                   - one pulse after each frame's last stop cycle
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16,
   parameter int DEF_DIV   = 5000
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic [DIV_W-1:0]     i_Div,
   input  logic                 i_Div_Load,
   input  logic [1:0]           i_Parity_Mode,
   input  logic                 i_Two_Stop,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Data,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Enable,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Done
);

   localparam int IDX_W = $clog2(DATA_BITS);

   uartState_t           state;
   logic [DIV_W-1:0]     divReg;
   logic [DIV_W-1:0]     frameDiv;
   logic                 frameParOn;
   logic                 frameTwoStop;
   logic                 holdFull;
   logic [DATA_BITS-1:0] holdData;
   logic [DATA_BITS-1:0] shiftReg;
   logic [IDX_W-1:0]     bitIdx;
   logic                 stopIdx;
   logic                 parBit;
   logic                 doneLag;

   logic                 tick;
   logic                 transfer;
   logic                 frameEnd;
   logic                 loadShifter;
   logic                 holdFullNext;
   logic                 serialNext;

   // The timer runs on the divisor frozen at frame start, so a divisor load
   // in the middle of a frame only affects the following frame.
   uart_bit_timer #(
      .DIV_W(DIV_W)
   ) bitTimer (
      .i_Clock  (i_Clock),
      .i_Rst_n  (i_Rst_n),
      .i_Div    (frameDiv),
      .i_Restart(loadShifter),
      .o_Tick   (tick)
   );

   // Handshake and sequencing decisions for this cycle. The shifter reloads
   // either from idle or on the very last stop cycle, which is what lets
   // chained frames run without an idle bit between them. The line value is
   // computed from the current state and registered, so every line output
   // trails the state by one cycle; that cycle is the holding-register delay
   // between a write and the start bit.
   always_comb begin
      transfer     = i_Tx_DV && o_Tx_Ready;
      frameEnd     = (state == STOP) && tick && (!frameTwoStop || stopIdx);
      loadShifter  = holdFull && ((state == IDLE) || frameEnd);
      holdFullNext = transfer || (holdFull && !loadShifter);
      serialNext   = 1'b1;
      case (state)
         START:   serialNext = 1'b0;
         DATA:    serialNext = shiftReg[0];
         PARITY:  serialNext = parBit;
         default: serialNext = 1'b1;
      endcase
   end

   // Main transmitter FSM with the holding register, divisor register and all
   // registered outputs. Reset aborts any frame in progress and discards a
   // held word. Frame format and divisor are captured when the shifter loads
   // and stay fixed until the next load. Done is delayed twice from the last
   // stop tick so it lands in the cycle after the last stop bit on the line.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         state        <= IDLE;
         divReg       <= DIV_W'(DEF_DIV);
         frameDiv     <= DIV_W'(DEF_DIV);
         frameParOn   <= 1'b0;
         frameTwoStop <= 1'b0;
         holdFull     <= 1'b0;
         holdData     <= '0;
         shiftReg     <= '0;
         bitIdx       <= '0;
         stopIdx      <= 1'b0;
         parBit       <= 1'b0;
         doneLag      <= 1'b0;
         o_Tx_Ready   <= 1'b0;
         o_Tx_Serial  <= 1'b1;
         o_Tx_Enable  <= 1'b0;
         o_Tx_Active  <= 1'b0;
         o_Tx_Done    <= 1'b0;
      end else begin
         if (i_Div_Load) begin
            divReg <= i_Div;
         end

         holdFull   <= holdFullNext;
         o_Tx_Ready <= !holdFullNext;
         if (transfer) begin
            holdData <= i_Tx_Data;
         end

         o_Tx_Serial <= serialNext;
         o_Tx_Enable <= (state != IDLE);
         o_Tx_Active <= (state != IDLE);
         doneLag     <= frameEnd;
         o_Tx_Done   <= doneLag;

         if (loadShifter) begin
            state        <= START;
            shiftReg     <= holdData;
            parBit       <= (^holdData) ^ (i_Parity_Mode == UART_PAR_ODD);
            frameParOn   <= parityEnabled(i_Parity_Mode);
            frameTwoStop <= i_Two_Stop;
            frameDiv     <= divReg;
         end else if (tick) begin
            case (state)
               START: begin
                  state  <= DATA;
                  bitIdx <= '0;
               end
               DATA: begin
                  shiftReg <= shiftReg >> 1;
                  if (bitIdx == IDX_W'(DATA_BITS - 1)) begin
                     stopIdx <= 1'b0;
                     state   <= frameParOn ? PARITY : STOP;
                  end else begin
                     bitIdx <= bitIdx + IDX_W'(1);
                  end
               end
               PARITY: begin
                  stopIdx <= 1'b0;
                  state   <= STOP;
               end
               STOP: begin
                  if (frameEnd) begin
                     state <= IDLE;
                  end else begin
                     stopIdx <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
